// File: rtl/small_lpf_channel_scheduler_if.sv
// small_lpf_channel_scheduler_if: sample-in / result-out handshake bundle for the shared LPF scheduler
//   in_valid/in_data/in_ready : per-channel sample stream, channel i at in_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready       : result handshake
//   out_ch/out_data           : channel tag and filtered word
interface small_lpf_channel_scheduler_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = 2
);
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_BITS-1:0]      out_ch;
    logic [WIDTH-1:0]        out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_ch, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_ch, out_data);
endinterface

// File: rtl/small_lpf_channel_scheduler.sv
// small_lpf_channel_scheduler: one shared single-pole IIR LPF update unit time-multiplexed over NUM_CH channels
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   clear_i : synchronous pulse, zeroes every channel state and blocks grants that cycle
//   bus     : slave side of the sample/result handshake interface
module small_lpf_channel_scheduler #(
    parameter int WIDTH     = 8,
    parameter int FILT_BITS = 8,
    parameter int NUM_CH    = 4,
    parameter int CH_BITS   = 2
) (
    input logic clk,
    input logic rst_n,
    input logic clear_i,
    small_lpf_channel_scheduler_if.slave bus
);
    localparam int SW = WIDTH + FILT_BITS;

    logic [SW-1:0]      state_q [NUM_CH];
    logic [CH_BITS-1:0] ptr_q;
    logic               out_valid_q;
    logic [CH_BITS-1:0] out_ch_q;
    logic [WIDTH-1:0]   out_data_q;

    logic               slot_free;
    logic               found;
    logic [CH_BITS-1:0] idx;
    logic [CH_BITS-1:0] gidx;
    logic [NUM_CH-1:0]  grant;
    logic [SW-1:0]      sel_state;
    logic [WIDTH-1:0]   sel_data;
    logic [SW-1:0]      state_d;
    logic [CH_BITS-1:0] ptr_d;

    assign slot_free = !out_valid_q || bus.out_ready;

    // Round-robin search starting at the pointer; grants are gated by reset so
    // in_ready falls the moment rst_n drops rather than at the next edge.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        if (rst_n && !clear_i && slot_free) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = CH_BITS'((int'(ptr_q) + k) % NUM_CH);
                if (!found && bus.in_valid[idx]) begin
                    found       = 1'b1;
                    gidx        = idx;
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    // y += x - y/2^N at full state width; the state can never exceed (2^WIDTH-1)*2^N.
    assign sel_state = state_q[gidx];
    assign sel_data  = bus.in_data[int'(gidx)*WIDTH +: WIDTH];
    assign state_d   = sel_state + SW'(sel_data) - SW'(sel_state[SW-1:FILT_BITS]);
    assign ptr_d     = (gidx == CH_BITS'(NUM_CH - 1)) ? '0 : gidx + CH_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            if (clear_i) begin
                for (int i = 0; i < NUM_CH; i++) state_q[i] <= '0;
            end else if (found) begin
                state_q[gidx] <= state_d;
            end
            if (found) begin
                ptr_q       <= ptr_d;
                out_valid_q <= 1'b1;
                out_ch_q    <= gidx;
                out_data_q  <= state_d[SW-1:FILT_BITS];
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
endmodule
